// File: rtl/band_ptt_ctrl.sv
// Band/PTT front-end: synchronise + debounce raw band selector and PTT, gate band changes
// through a blanking interval, and lock out transmit after a time-out.
// Latency: raw -> ptt is 2 sync + DB_CYCLES debounce + 1 registered output cycles.
// No backpressure: free-running control path, all outputs registered.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset (release synchronised internally)
//   band_sel     raw 3-bit band selector, asynchronous to clk
//   ptt_in       raw PTT, active-low
//   tot_en       1 enables the transmit time-out timer
//   band         band code to the mux (000 = off, 1xx = valid band)
//   ptt          PTT to the sequencer, active-low
//   tot_expired  high while in time-out lockout
//   busy         high while blanking between bands

// Synchroniser + debouncer for one raw input bus.
// Latency: 2 sync cycles, then DB_CYCLES stable samples before db_o updates.
// No backpressure.
module band_ptt_db #(
  parameter int unsigned W         = 1,
  parameter int unsigned DB_CYCLES = 1000,
  parameter logic [W-1:0] RST_VAL  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] db_o
);
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [W-1:0]  s1_q, s2_q, s3_q, db_q;
  logic [CW-1:0] cnt_q, cnt_base_d;

  // A fresh change in the synchronised value restarts the stability count;
  // the current sample is then the first of the new run.
  always_comb begin
    cnt_base_d = cnt_q;
    if (s2_q != s3_q) cnt_base_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= RST_VAL;
      s2_q  <= RST_VAL;
      s3_q  <= RST_VAL;
      db_q  <= RST_VAL;
      cnt_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (s2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_base_d == CNT_LAST) begin
        db_q  <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_base_d + CW'(1);
      end
    end
  end

  assign db_o = db_q;
endmodule

module band_ptt_ctrl #(
  parameter int unsigned DB_CYCLES    = 1000,
  parameter int unsigned BLANK_CYCLES = 5000,
  parameter int unsigned TOT_CYCLES   = 60000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] band_sel,
  input  logic       ptt_in,
  input  logic       tot_en,
  output logic [2:0] band,
  output logic       ptt,
  output logic       tot_expired,
  output logic       busy
);
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
  localparam int unsigned TW = $clog2(TOT_CYCLES + 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] TOT_LAST   = TW'(TOT_CYCLES - 1);

  typedef enum logic [1:0] {S_RX, S_BLANK, S_TX, S_LOCK} state_t;

  // Reset asserts immediately through the async clear, releases two clocks later.
  logic rst_meta_q, rst_sync_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic [2:0] band_db;
  logic       ptt_db;

  band_ptt_db #(.W(3), .DB_CYCLES(DB_CYCLES), .RST_VAL(3'b000)) u_band_db (
    .clk   (clk),
    .rst_n (rst_sync_q),
    .raw_i (band_sel),
    .db_o  (band_db)
  );

  band_ptt_db #(.W(1), .DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_ptt_db (
    .clk   (clk),
    .rst_n (rst_sync_q),
    .raw_i (ptt_in),
    .db_o  (ptt_db)
  );

  state_t        state_q;
  logic [2:0]    cur_band_q, blank_tgt_q, band_q;
  logic [BW-1:0] blank_cnt_q;
  logic [TW-1:0] tot_cnt_q;
  logic          ptt_q, tot_exp_q, busy_q;
  logic          cur_valid;

  assign cur_valid = cur_band_q[2];

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q     <= S_RX;
      cur_band_q  <= 3'b000;
      blank_tgt_q <= 3'b000;
      band_q      <= 3'b000;
      blank_cnt_q <= '0;
      tot_cnt_q   <= '0;
      ptt_q       <= 1'b1;
      tot_exp_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_RX: begin
          if (band_db != cur_band_q) begin
            state_q     <= S_BLANK;
            band_q      <= 3'b000;
            busy_q      <= 1'b1;
            ptt_q       <= 1'b1;
            blank_cnt_q <= BLANK_LAST;
            blank_tgt_q <= band_db;
          end else if (!ptt_db && cur_valid) begin
            state_q   <= S_TX;
            ptt_q     <= 1'b0;
            tot_cnt_q <= '0;
            band_q    <= cur_band_q;
          end else begin
            ptt_q  <= 1'b1;
            band_q <= cur_valid ? cur_band_q : 3'b000;
          end
        end

        S_BLANK: begin
          // Any further selector movement restarts a full blank interval so the
          // relays always get the whole settle time after the last change.
          if (band_db != blank_tgt_q) begin
            blank_cnt_q <= BLANK_LAST;
            blank_tgt_q <= band_db;
          end else if (blank_cnt_q == '0) begin
            state_q    <= S_RX;
            cur_band_q <= blank_tgt_q;
            band_q     <= blank_tgt_q[2] ? blank_tgt_q : 3'b000;
            busy_q     <= 1'b0;
          end else begin
            blank_cnt_q <= blank_cnt_q - BW'(1);
          end
        end

        S_TX: begin
          // Release wins over a simultaneous time-out.
          if (ptt_db) begin
            state_q   <= S_RX;
            ptt_q     <= 1'b1;
            tot_cnt_q <= '0;
          end else if (tot_en) begin
            tot_cnt_q <= tot_cnt_q + TW'(1);
            if (tot_cnt_q == TOT_LAST) begin
              state_q   <= S_LOCK;
              ptt_q     <= 1'b1;
              tot_exp_q <= 1'b1;
            end
          end else begin
            tot_cnt_q <= '0;
          end
        end

        S_LOCK: begin
          if (ptt_db) begin
            state_q   <= S_RX;
            tot_exp_q <= 1'b0;
            tot_cnt_q <= '0;
          end
        end

        default: begin
          state_q <= S_RX;
        end
      endcase
    end
  end

  assign band        = band_q;
  assign ptt         = ptt_q;
  assign tot_expired = tot_exp_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_band_ptt_ctrl.sv
// Directed bench for band_ptt_ctrl with small debounce/blank/time-out parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// All expected values are hand-derived cycle counts from the raw input change.
module tb_band_ptt_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] band_sel;
  logic       ptt_in;
  logic       tot_en;
  logic [2:0] band;
  logic       ptt;
  logic       tot_expired;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  band_ptt_ctrl #(.DB_CYCLES(4), .BLANK_CYCLES(8), .TOT_CYCLES(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .band_sel    (band_sel),
    .ptt_in      (ptt_in),
    .tot_en      (tot_en),
    .band        (band),
    .ptt         (ptt),
    .tot_expired (tot_expired),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  cnt;
    bit  seen;
    bit  bad;

    reset    = 1'b0;
    band_sel = 3'b100;
    ptt_in   = 1'b1;
    tot_en   = 1'b0;
    step(3);
    chk("rst_band", band, 3'b000);
    chk("rst_ptt", ptt, 1'b1);
    chk("rst_tot", tot_expired, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // 1: band 100 debounced, 8 cycles of blank, then 100
    reset = 1'b1;
    seen = 0;
    bad  = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step(1);
      if (busy) seen = 1;
      else if (band != 3'b000) bad = 1;
    end
    chk("t1_busy_seen", seen, 1);
    cnt = 0;
    while (busy && cnt < 40) begin
      if (band != 3'b000) bad = 1;
      cnt++;
      step(1);
    end
    chk("t1_blank_len", cnt, 8);
    chk("t1_band_zero_before", bad, 0);
    chk("t1_band", band, 3'b100);

    // 2: 3-cycle PTT glitch rejected
    ptt_in = 1'b0;
    step(3);
    ptt_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (ptt != 1'b1) bad = 1;
    end
    chk("t2_glitch_ptt", bad, 0);
    chk("t2_band", band, 3'b100);

    // 3: press -> ptt 0 at 7th edge, holds with tot_en=0, release -> 1 at 7th edge
    ptt_in = 1'b0;
    step(6);
    chk("t3_ptt_edge6", ptt, 1'b1);
    step(1);
    chk("t3_ptt_edge7", ptt, 1'b0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (ptt != 1'b0 || tot_expired != 1'b0) bad = 1;
    end
    chk("t3_hold", bad, 0);
    ptt_in = 1'b1;
    step(6);
    chk("t3_rel_edge6", ptt, 1'b0);
    step(1);
    chk("t3_rel_edge7", ptt, 1'b1);

    // 4: band change during TX is deferred until after release
    ptt_in = 1'b0;
    step(7);
    chk("t4_tx", ptt, 1'b0);
    band_sel = 3'b101;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (band != 3'b100 || busy) bad = 1;
    end
    chk("t4_band_frozen", bad, 0);
    ptt_in = 1'b1;
    step(7);
    chk("t4_rel_ptt", ptt, 1'b1);
    chk("t4_rel_band", band, 3'b100);
    step(1);
    chk("t4_blank_start", band, 3'b000);
    chk("t4_busy_start", busy, 1'b1);
    step(7);
    chk("t4_blank_end", band, 3'b000);
    chk("t4_busy_end", busy, 1'b1);
    step(1);
    chk("t4_new_band", band, 3'b101);
    chk("t4_busy_clr", busy, 1'b0);

    // 5: time-out after 20 TX cycles, lockout until release, re-press works
    tot_en = 1'b1;
    ptt_in = 1'b0;
    step(7);
    chk("t5_tx", ptt, 1'b0);
    step(19);
    chk("t5_ptt_19", ptt, 1'b0);
    chk("t5_tot_19", tot_expired, 1'b0);
    step(1);
    chk("t5_ptt_20", ptt, 1'b1);
    chk("t5_tot_20", tot_expired, 1'b1);
    step(10);
    chk("t5_lock_hold", {ptt, tot_expired}, 2'b11);
    ptt_in = 1'b1;
    step(6);
    chk("t5_lock_rel6", tot_expired, 1'b1);
    step(1);
    chk("t5_lock_rel7", tot_expired, 1'b0);
    chk("t5_rx_ptt", ptt, 1'b1);
    ptt_in = 1'b0;
    step(7);
    chk("t5_repress", {ptt, tot_expired}, 2'b00);
    ptt_in = 1'b1;
    tot_en = 1'b0;
    step(7);
    chk("t5_release", ptt, 1'b1);

    // 6: invalid band refuses TX; reset mid-TX takes effect immediately
    band_sel = 3'b011;
    step(20);
    chk("t6_band_inv", band, 3'b000);
    chk("t6_busy", busy, 1'b0);
    ptt_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ptt != 1'b1) bad = 1;
    end
    chk("t6_ptt_refused", bad, 0);
    band_sel = 3'b100;
    step(16);
    chk("t6_tx_ptt", ptt, 1'b0);
    chk("t6_tx_band", band, 3'b100);
    step(3);
    reset = 1'b0;
    #1;
    chk("t6_rst_ptt", ptt, 1'b1);
    chk("t6_rst_band", band, 3'b000);
    chk("t6_rst_busy", busy, 1'b0);
    step(2);
    reset = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
